// File: rtl/mem_pkg.sv
// Shared definitions for the latency-configurable data memory.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP
  } state_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane steering: store enables/replication, load extract/extend,
// and size/alignment checking.
module dmem_lane
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        misalign
);

  logic [31:0] shifted;

  assign shifted = rword >> {lane, 3'b000};

  always_comb begin
    be       = '0;
    wword    = '0;
    rdata    = '0;
    misalign = 1'b0;
    case (size)
      SZ_BYTE: begin
        be    = BE_BYTE << lane;
        wword = {4{wdata[7:0]}};
        rdata = {{24{sgn & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        misalign = lane[0];
        be       = BE_HALF << lane;
        wword    = {2{wdata[15:0]}};
        rdata    = {{16{sgn & shifted[15]}}, shifted[15:0]};
      end
      SZ_WORD: begin
        misalign = |lane;
        be       = BE_WORD;
        wword    = wdata;
        rdata    = rword;
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_wait.sv
// Data memory with valid/ready request, fixed wait latency and
// sub-word access; one transaction in flight at a time.
module dmem_wait
  import mem_pkg::*;
#(
  parameter  int DEPTH   = 64,
  parameter  int LATENCY = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  logic [31:0] ram [DEPTH];

  state_e      state;
  logic [3:0]  cnt;
  logic        q_we;
  logic [1:0]  q_size;
  logic        q_sgn;
  logic [31:0] q_addr;
  logic [31:0] q_wdata;

  logic [AW-1:0] idx;
  logic [3:0]    be;
  logic [31:0]   wword;
  logic [31:0]   lrdata;
  logic          misalign;
  logic          oor;
  logic          err;

  assign idx = q_addr[AW+1:2];
  assign oor = |q_addr[31:AW+2];
  assign err = misalign | oor;

  dmem_lane u_lane (
    .size     (q_size),
    .sgn      (q_sgn),
    .lane     (q_addr[1:0]),
    .wdata    (q_wdata),
    .rword    (ram[idx]),
    .be       (be),
    .wword    (wword),
    .rdata    (lrdata),
    .misalign (misalign)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      req_ready  <= 1'b1;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          q_we      <= req_we;
          q_size    <= req_size;
          q_sgn     <= req_signed;
          q_addr    <= req_addr;
          q_wdata   <= req_wdata;
          cnt       <= 4'(LATENCY);
          req_ready <= 1'b0;
          state     <= (LATENCY > 0) ? WAIT : ACCESS;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1)
            state <= ACCESS;
        end
        ACCESS: begin
          resp_valid <= 1'b1;
          resp_err   <= err;
          resp_rdata <= (err || q_we) ? '0 : lrdata;
          state      <= RESP;
        end
        RESP: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reset at the ACCESS edge must suppress the commit too.
  always_ff @(posedge clk) begin
    if (!reset && state == ACCESS && q_we && !err) begin
      for (int i = 0; i < 4; i++)
        if (be[i])
          ram[idx][8*i +: 8] <= wword[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_dmem_wait.sv
// Directed bench: three instances (LATENCY 1, 0, 15) driven from a
// vector table, plus a reset-abort sequence.
module tb_dmem_wait;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rv  [N];
  logic        rdy [N];
  logic        we  [N];
  logic [1:0]  sz  [N];
  logic        sg  [N];
  logic [31:0] ad  [N];
  logic [31:0] wd  [N];
  logic        vld [N];
  logic [31:0] rd  [N];
  logic        er  [N];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    dmem_wait #(
      .DEPTH   (64),
      .LATENCY (g == 0 ? 1 : (g == 1 ? 0 : 15))
    ) u (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (rv[g]),
      .req_ready  (rdy[g]),
      .req_we     (we[g]),
      .req_size   (sz[g]),
      .req_signed (sg[g]),
      .req_addr   (ad[g]),
      .req_wdata  (wd[g]),
      .resp_valid (vld[g]),
      .resp_rdata (rd[g]),
      .resp_err   (er[g])
    );
  end

  typedef struct {
    int          d;
    logic        w;
    logic [1:0]  s;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] wdat;
    logic [31:0] exp_r;
    logic        exp_e;
  } vec_t;

  vec_t vecs [$];

  function automatic int lat_of(int d);
    return d == 0 ? 1 : (d == 1 ? 0 : 15);
  endfunction

  function automatic vec_t mk(int d, logic w, logic [1:0] s, logic sgn,
                              logic [31:0] a, logic [31:0] wdat,
                              logic [31:0] exp_r, logic exp_e);
    vec_t v;
    v.d = d; v.w = w; v.s = s; v.sgn = sgn;
    v.a = a; v.wdat = wdat; v.exp_r = exp_r; v.exp_e = exp_e;
    return v;
  endfunction

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  // Called #1 after a posedge; holds req_valid high until the response.
  task automatic req(input int d, input logic w, input logic [1:0] s,
                     input logic sgn, input logic [31:0] a,
                     input logic [31:0] wdat, input string n,
                     output logic [31:0] r, output logic e);
    int k;
    int busy_bad;
    chk({n, "_ready_idle"}, 32'(rdy[d]), 32'd1);
    rv[d] = 1'b1; we[d] = w; sz[d] = s; sg[d] = sgn;
    ad[d] = a; wd[d] = wdat;
    @(posedge clk); #1;
    k = 0;
    busy_bad = 0;
    while (!vld[d] && k < 40) begin
      if (rdy[d]) busy_bad++;
      @(posedge clk); #1;
      k++;
    end
    if (rdy[d]) busy_bad++;
    r = rd[d];
    e = er[d];
    rv[d] = 1'b0;
    chk({n, "_latency"}, 32'(k), 32'(lat_of(d) + 1));
    chk({n, "_ready_busy"}, 32'(busy_bad), 32'd0);
    @(posedge clk); #1;
    chk({n, "_pulse_end"}, 32'(vld[d]), 32'd0);
    chk({n, "_ready_after"}, 32'(rdy[d]), 32'd1);
  endtask

  initial begin
    logic [31:0] r;
    logic        e;
    int          spurious;

    for (int i = 0; i < N; i++) begin
      rv[i] = 1'b0; we[i] = 1'b0; sz[i] = 2'b10; sg[i] = 1'b0;
      ad[i] = '0; wd[i] = '0;
    end

    vecs.push_back(mk(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0));
    vecs.push_back(mk(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0));
    vecs.push_back(mk(0, 1, 2'b00, 0, 32'h11, 32'hFFFFFF7A, 32'h0, 0));
    vecs.push_back(mk(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEAD7AEF, 0));
    vecs.push_back(mk(0, 0, 2'b00, 1, 32'h13, 32'h0, 32'hFFFFFFDE, 0));
    vecs.push_back(mk(0, 0, 2'b00, 0, 32'h13, 32'h0, 32'h000000DE, 0));
    vecs.push_back(mk(0, 0, 2'b01, 1, 32'h12, 32'h0, 32'hFFFFDEAD, 0));
    vecs.push_back(mk(0, 0, 2'b01, 0, 32'h10, 32'h0, 32'h00007AEF, 0));
    vecs.push_back(mk(0, 0, 2'b10, 1, 32'h10, 32'h0, 32'hDEAD7AEF, 0));
    vecs.push_back(mk(0, 1, 2'b10, 0, 32'h20, 32'h01234567, 32'h0, 0));
    vecs.push_back(mk(0, 1, 2'b01, 0, 32'h21, 32'h0000BEEF, 32'h0, 1));
    vecs.push_back(mk(0, 0, 2'b10, 0, 32'h22, 32'h0, 32'h0, 1));
    vecs.push_back(mk(0, 0, 2'b11, 0, 32'h20, 32'h0, 32'h0, 1));
    vecs.push_back(mk(0, 0, 2'b10, 0, 32'h100, 32'h0, 32'h0, 1));
    vecs.push_back(mk(0, 1, 2'b11, 0, 32'h20, 32'hFFFFFFFF, 32'h0, 1));
    vecs.push_back(mk(0, 1, 2'b10, 0, 32'h80000020, 32'hFFFFFFFF, 32'h0, 1));
    vecs.push_back(mk(0, 0, 2'b10, 0, 32'h20, 32'h0, 32'h01234567, 0));
    vecs.push_back(mk(0, 1, 2'b01, 0, 32'h22, 32'h1111CAFE, 32'h0, 0));
    vecs.push_back(mk(0, 0, 2'b10, 0, 32'h20, 32'h0, 32'hCAFE4567, 0));
    vecs.push_back(mk(0, 0, 2'b00, 1, 32'h21, 32'h0, 32'h00000045, 0));
    vecs.push_back(mk(0, 0, 2'b01, 1, 32'h20, 32'h0, 32'h00004567, 0));
    vecs.push_back(mk(0, 0, 2'b00, 1, 32'h23, 32'h0, 32'hFFFFFFCA, 0));
    vecs.push_back(mk(1, 1, 2'b10, 0, 32'h40, 32'h89ABCDEF, 32'h0, 0));
    vecs.push_back(mk(1, 0, 2'b00, 0, 32'h42, 32'h0, 32'h000000AB, 0));
    vecs.push_back(mk(1, 0, 2'b01, 1, 32'h42, 32'h0, 32'hFFFF89AB, 0));
    vecs.push_back(mk(1, 0, 2'b10, 0, 32'h41, 32'h0, 32'h0, 1));
    vecs.push_back(mk(2, 1, 2'b10, 0, 32'h30, 32'hAAAA5555, 32'h0, 0));
    vecs.push_back(mk(2, 0, 2'b10, 0, 32'h30, 32'h0, 32'hAAAA5555, 0));
    vecs.push_back(mk(2, 0, 2'b01, 0, 32'h32, 32'h0, 32'h0000AAAA, 0));

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst_ready%0d", i), 32'(rdy[i]), 32'd1);
      chk($sformatf("rst_valid%0d", i), 32'(vld[i]), 32'd0);
      chk($sformatf("rst_rdata%0d", i), rd[i], 32'd0);
      chk($sformatf("rst_err%0d", i), 32'(er[i]), 32'd0);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      string n;
      n = $sformatf("v%0d", i);
      req(vecs[i].d, vecs[i].w, vecs[i].s, vecs[i].sgn, vecs[i].a,
          vecs[i].wdat, n, r, e);
      chk({n, "_rdata"}, r, vecs[i].exp_r);
      chk({n, "_err"}, 32'(e), 32'(vecs[i].exp_e));
    end

    // Abort a LATENCY=15 store in WAIT; the old word must survive.
    rv[2] = 1'b1; we[2] = 1'b1; sz[2] = 2'b10; sg[2] = 1'b0;
    ad[2] = 32'h30; wd[2] = 32'h12345678;
    @(posedge clk); #1;
    rv[2] = 1'b0;
    spurious = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (vld[2]) spurious++;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_ready", 32'(rdy[2]), 32'd1);
    chk("abort_valid", 32'(vld[2]), 32'd0);
    repeat (20) begin
      @(posedge clk); #1;
      if (vld[2]) spurious++;
    end
    chk("abort_no_resp", 32'(spurious), 32'd0);
    req(2, 0, 2'b10, 0, 32'h30, 32'h0, "abort_load", r, e);
    chk("abort_load_rdata", r, 32'hAAAA5555);
    chk("abort_load_err", 32'(e), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
